// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 10-bit frame shifted out
// on device clock falls, then device ACK check. Drives the pins via pull-low enables.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_HOLD     = 50,
   parameter int START_TIMEOUT  = 750000,
   parameter int PACKET_TIMEOUT = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       send_cmd,
   input  logic [7:0] cmd_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);

   localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] START_LOAD   = 20'(START_HOLD - 1);
   localparam logic [19:0] WAIT_LOAD    = 20'(START_TIMEOUT - 1);
   localparam logic [19:0] PACKET_LOAD  = 20'(PACKET_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, START, WAIT_CLK, SHIFT, ACK, DONE, ERR} state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_t      state_r, state_n;
   logic [19:0] count_r, count_n;
   logic [9:0]  shift_r, shift_n;
   logic [3:0]  bitcnt_r, bitcnt_n;
   logic        dat_oe_n;
   logic [1:0]  code_n;
   logic        clk_s1_r, clk_sync_r, clk_prev_r, dat_s1_r, dat_sync_r;
   logic        fall_s;

   // Two-flop synchronizers plus previous-clock flop for fall detection; lines idle high.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_s1_r   <= 1'b1;
         clk_sync_r <= 1'b1;
         clk_prev_r <= 1'b1;
         dat_s1_r   <= 1'b1;
         dat_sync_r <= 1'b1;
      end else begin
         clk_s1_r   <= ps2_clk_in;
         clk_sync_r <= clk_s1_r;
         clk_prev_r <= clk_sync_r;
         dat_s1_r   <= ps2_dat_in;
         dat_sync_r <= dat_s1_r;
      end
   end

   assign fall_s = clk_prev_r & ~clk_sync_r;

   // Next-state, shared down-counter, frame shifter and next data-enable value.
   always_comb begin
      state_n  = state_r;
      count_n  = (count_r != 20'd0) ? (count_r - 20'd1) : count_r;
      shift_n  = shift_r;
      bitcnt_n = bitcnt_r;
      dat_oe_n = ps2_dat_oe;
      code_n   = err_code;
      case (state_r)
         IDLE: begin
            if (send_cmd && ready) begin
               shift_n  = {1'b1, odd_parity(cmd_data), cmd_data};
               count_n  = INHIBIT_LOAD;
               bitcnt_n = 4'd0;
               state_n  = INHIBIT;
            end else begin
               count_n = count_r;
            end
         end
         INHIBIT: begin
            if (count_r == 20'd0) begin
               count_n = START_LOAD;
               state_n = START;
            end else begin
               state_n = INHIBIT;
            end
         end
         START: begin
            if (count_r == 20'd0) begin
               count_n = WAIT_LOAD;
               state_n = WAIT_CLK;
            end else begin
               state_n = START;
            end
         end
         WAIT_CLK: begin
            if (fall_s) begin
               dat_oe_n = ~shift_r[0];
               shift_n  = {1'b1, shift_r[9:1]};
               bitcnt_n = 4'd1;
               count_n  = PACKET_LOAD;
               state_n  = SHIFT;
            end else if (count_r == 20'd0) begin
               code_n  = 2'b01;
               state_n = ERR;
            end else begin
               state_n = WAIT_CLK;
            end
         end
         SHIFT: begin
            // Fall takes priority over an expiring counter in the same cycle.
            if (fall_s) begin
               dat_oe_n = ~shift_r[0];
               shift_n  = {1'b1, shift_r[9:1]};
               bitcnt_n = bitcnt_r + 4'd1;
               if (bitcnt_r == 4'd9) begin
                  state_n = ACK;
               end else begin
                  state_n = SHIFT;
               end
            end else if (count_r == 20'd0) begin
               code_n  = 2'b10;
               state_n = ERR;
            end else begin
               state_n = SHIFT;
            end
         end
         ACK: begin
            if (fall_s) begin
               if (dat_sync_r == 1'b0) begin
                  state_n = DONE;
               end else begin
                  code_n  = 2'b11;
                  state_n = ERR;
               end
            end else if (count_r == 20'd0) begin
               code_n  = 2'b10;
               state_n = ERR;
            end else begin
               state_n = ACK;
            end
         end
         DONE:    state_n = IDLE;
         ERR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
      case (state_n)
         START:    dat_oe_n = 1'b1;
         WAIT_CLK: dat_oe_n = dat_oe_n;
         SHIFT:    dat_oe_n = dat_oe_n;
         default:  dat_oe_n = 1'b0;
      endcase
   end

   // State, datapath and registered outputs derived from the next state.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r    <= IDLE;
         count_r    <= 20'd0;
         shift_r    <= 10'd0;
         bitcnt_r   <= 4'd0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         ready      <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_code   <= 2'b00;
      end else begin
         state_r    <= state_n;
         count_r    <= count_n;
         shift_r    <= shift_n;
         bitcnt_r   <= bitcnt_n;
         ps2_clk_oe <= (state_n == INHIBIT) || (state_n == START);
         ps2_dat_oe <= dat_oe_n;
         ready      <= (state_n == IDLE);
         busy       <= (state_n != IDLE);
         done       <= (state_n == DONE);
         error      <= (state_n == ERR);
         err_code   <= code_n;
      end
   end

endmodule
